stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Control block for the stopwatch counter. It produces the 1 kHz count-enable that the counter uses in place of free-running counting. It also provides a 2-FF synchroniser and debouncer for the two front-panel buttons, a run/lap/stop/idle state machine that decides when the counter advances, and a single-cycle clear pulse that zeroes the counter and releases the display freeze.

## Interface
- CLK_HZ, 50_000_000, system clock frequency in Hz
- TICK_HZ, 1000, count-enable rate in Hz; DIV = CLK_HZ/TICK_HZ, an integer ≥ 2
- DB_TICKS, 20, number of consecutive ms_ticks a synchronised button level must hold before it is accepted
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-low; one clock; all state is cleared while low
- btn_start_stop  in  1  raw button, asynchronous to clk, active-high (pressed = 1)
- btn_lap_reset  in  1  raw button, asynchronous to clk, active-high
- ms_tick  out  1  free-running 1-cycle pulse, once every DIV cycles
- count_en  out  1  ms_tick gated by state ∈ {RUN, LAP}; drives counter advance
- clear  out  1  1-cycle pulse; counter zeroes its fields
- lap_freeze  out  1  level; display holds its last value while counting continues
- state  out  2  IDLE=0, RUN=1, LAP=2, STOP=3

## Operation
- Prescaler: counter of width clog2(DIV), counts 0..DIV-1 and wraps to 0.
  - ms_tick=1 while the counter is DIV-1.
  - The counter is forced to 0 on the edge that takes IDLE→RUN, and on the edge that asserts clear.
- Synchroniser: each button passes through 2 FFs (reset 0).
- Debouncer, per button:
  - Holds a `stable` bit (reset 0) and a debounce counter, width clog2(DB_TICKS+1).
  - While sync == stable, the counter is held at 0.
  - Otherwise the counter increments on each ms_tick. When it reaches DB_TICKS, stable <= sync and the counter returns to 0.
  - press_ev is a registered 1-cycle pulse on the 0→1 transition of stable. Releases generate no event.
- State machine, updated on the edge where an event is high:
  - IDLE: ss → RUN; lr → no-op.
  - RUN: ss → STOP; lr → LAP, setting lap_freeze=1.
  - LAP: ss → STOP, setting lap_freeze=0; lr → RUN, setting lap_freeze=0.
  - STOP: ss → RUN; lr → IDLE and clear=1 for exactly one cycle.
- Simultaneous ss and lr events in the same cycle: ss is applied and lr is discarded.
- count_en = ms_tick & (state==RUN | state==LAP). The prescaler keeps running in IDLE and STOP.
- clear is registered. It is high in the first cycle that state reads IDLE after STOP.

## Timing
- Reset-asserted values, applied immediately (asynchronous) and held until the first edge after release:
  - state=IDLE; ms_tick, count_en, clear, lap_freeze = 0.
  - Prescaler, debounce counters, stable bits and sync FFs = 0.
- Latency from raw button to state change:
  - 2 cycles of synchronisation.
  - DB_TICKS ms_ticks with sync ≠ stable.
  - press_ev one cycle after stable updates.
  - state/lap_freeze/clear visible one cycle after press_ev.
- A bounce that returns sync to the stable value resets the debounce counter. Any glitch shorter than DB_TICKS ms_ticks yields no event.
- After the IDLE→RUN edge, the first count_en occurs exactly DIV cycles later, and every DIV cycles after that.
- STOP→RUN does not reset the prescaler. The partial millisecond is kept.
- reset low mid-operation in any state: outputs go to their reset values with no clk edge required. No clear pulse is emitted.

## Test plan
Bench parameters: CLK_HZ=1000, TICK_HZ=100 (DIV=10), DB_TICKS=2.
- Release reset, no buttons, 100 cycles:
  - ms_tick on cycles 9, 19, 29 and so on (10 pulses in total).
  - count_en=0, state=0, clear=0.
- Hold btn_start_stop high for 60 cycles (clean press):
  - Exactly one press_ev.
  - state=1 one cycle later.
  - First count_en 10 cycles after the state change, then one every 10 cycles.
- Bounce btn_start_stop every 3 cycles for 18 cycles, then hold high:
  - Exactly one state transition, IDLE→RUN.
  - No transition while bouncing.
- In RUN, press lr:
  - state=2, lap_freeze=1, count_en continues every 10 cycles.
  - Press lr again: state=1, lap_freeze=0.
- In RUN, press ss: state=3, count_en stays 0. Then press lr:
  - state=0, clear high for exactly 1 cycle.
  - Prescaler restarts, so the next ms_tick comes 10 cycles after clear.
- Simultaneous presses and mid-run reset:
  - In RUN, press both buttons in the same cycle: state=3, lap_freeze=0, the lr event is dropped.
  - Then drive reset low mid-cycle: state=0 and all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: 1 kHz count-enable prescaler, button synchronise/debounce,
// and the IDLE/RUN/LAP/STOP state machine that drives clear and lap_freeze.
module stopwatch_ctrl #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int TICK_HZ  = 1000,
  parameter int DB_TICKS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_lap_reset,
  output logic       ms_tick,
  output logic       count_en,
  output logic       clear,
  output logic       lap_freeze,
  output logic [1:0] state
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DW  = (DB_TICKS > 0) ? $clog2(DB_TICKS + 1) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [DW-1:0] DMAX = DW'(DB_TICKS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAP  = 2'd2,
    STOP = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_freeze, w_freeze_nxt;
  logic            r_clear, w_clear_nxt;
  logic            w_presc_zero;
  logic [PW-1:0]   r_presc;
  logic            w_tick;

  // Bit 0 = start/stop, bit 1 = lap/reset.
  logic [1:0]      w_raw;
  logic [1:0]      r_meta, r_sync, r_stable, r_stable_d, r_ev;
  logic [DW-1:0]   r_dbc [2];
  logic            w_ss, w_lr;

  assign w_raw  = {btn_lap_reset, btn_start_stop};
  assign w_tick = (r_presc == PMAX);
  assign w_ss   = r_ev[0];
  assign w_lr   = r_ev[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
    end else if (w_presc_zero) begin
      r_presc <= '0;
    end else if (r_presc == PMAX) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // A level is accepted only after it differs from stable for DB_TICKS ticks;
  // any return to the stable level restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta     <= '0;
      r_sync     <= '0;
      r_stable   <= '0;
      r_stable_d <= '0;
      r_ev       <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_dbc[i] <= '0;
      end
    end else begin
      r_meta     <= w_raw;
      r_sync     <= r_meta;
      r_stable_d <= r_stable;
      r_ev       <= r_stable & ~r_stable_d;
      for (int unsigned i = 0; i < 2; i++) begin
        if (r_sync[i] == r_stable[i]) begin
          r_dbc[i] <= '0;
        end else if (r_dbc[i] == DMAX) begin
          r_stable[i] <= r_sync[i];
          r_dbc[i]    <= '0;
        end else if (w_tick) begin
          r_dbc[i] <= r_dbc[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_freeze <= 1'b0;
      r_clear  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_freeze <= w_freeze_nxt;
      r_clear  <= w_clear_nxt;
    end
  end

  // Start/stop has priority: a simultaneous lap/reset event is dropped.
  always_comb begin
    w_state_nxt  = r_state;
    w_freeze_nxt = r_freeze;
    w_clear_nxt  = 1'b0;
    w_presc_zero = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ss) begin
          w_state_nxt  = RUN;
          w_presc_zero = 1'b1;
        end
      end
      RUN: begin
        if (w_ss) begin
          w_state_nxt = STOP;
        end else if (w_lr) begin
          w_state_nxt  = LAP;
          w_freeze_nxt = 1'b1;
        end
      end
      LAP: begin
        if (w_ss) begin
          w_state_nxt  = STOP;
          w_freeze_nxt = 1'b0;
        end else if (w_lr) begin
          w_state_nxt  = RUN;
          w_freeze_nxt = 1'b0;
        end
      end
      STOP: begin
        if (w_ss) begin
          w_state_nxt = RUN;
        end else if (w_lr) begin
          w_state_nxt  = IDLE;
          w_clear_nxt  = 1'b1;
          w_presc_zero = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign ms_tick    = w_tick;
  assign count_en   = w_tick & ((r_state == RUN) | (r_state == LAP));
  assign clear      = r_clear;
  assign lap_freeze = r_freeze;
  assign state      = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: table of button presses with expected
// state/freeze/clear, plus sequences for tick timing, bounce, clear and reset.
module tb_stopwatch_ctrl;

  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       b_ss = 1'b0;
  logic       b_lr = 1'b0;
  logic       ms_tick, count_en, clear, lap_freeze;
  logic [1:0] state;

  int n_vec = 0;
  int n_err = 0;
  int n_trans = 0;
  int n_clr = 0;
  logic [1:0] prev_state = 2'd0;

  typedef struct {
    bit ss;
    bit lr;
    int st;
    bit fz;
    int clr;
  } vec_t;

  vec_t tbl [16];

  stopwatch_ctrl #(
    .CLK_HZ  (1000),
    .TICK_HZ (100),
    .DB_TICKS(2)
  ) dut (
    .clk           (clk),
    .reset         (rst_n),
    .btn_start_stop(b_ss),
    .btn_lap_reset (b_lr),
    .ms_tick       (ms_tick),
    .count_en      (count_en),
    .clear         (clear),
    .lap_freeze    (lap_freeze),
    .state         (state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (state != prev_state) n_trans++;
    prev_state = state;
    if (clear) n_clr++;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic press(input bit ss, input bit lr);
    b_ss = ss;
    b_lr = lr;
    repeat (60) @(negedge clk);
    b_ss = 1'b0;
    b_lr = 1'b0;
    repeat (60) @(negedge clk);
  endtask

  initial begin
    int s, e1, e2, c, t, st_c, nce, nclr, nt, ce, cl, sn, t0, k0, exp_prev;
    bit found;

    tbl[0]  = '{1'b1, 1'b0, 1, 1'b0, 0};
    tbl[1]  = '{1'b0, 1'b1, 2, 1'b1, 0};
    tbl[2]  = '{1'b0, 1'b1, 1, 1'b0, 0};
    tbl[3]  = '{1'b0, 1'b1, 2, 1'b1, 0};
    tbl[4]  = '{1'b1, 1'b0, 3, 1'b0, 0};
    tbl[5]  = '{1'b1, 1'b0, 1, 1'b0, 0};
    tbl[6]  = '{1'b1, 1'b0, 3, 1'b0, 0};
    tbl[7]  = '{1'b0, 1'b1, 0, 1'b0, 1};
    tbl[8]  = '{1'b0, 1'b1, 0, 1'b0, 0};
    tbl[9]  = '{1'b1, 1'b0, 1, 1'b0, 0};
    tbl[10] = '{1'b1, 1'b1, 3, 1'b0, 0};
    tbl[11] = '{1'b0, 1'b1, 0, 1'b0, 1};
    tbl[12] = '{1'b1, 1'b0, 1, 1'b0, 0};
    tbl[13] = '{1'b0, 1'b1, 2, 1'b1, 0};
    tbl[14] = '{1'b1, 1'b1, 3, 1'b0, 0};
    tbl[15] = '{1'b1, 1'b0, 1, 1'b0, 0};

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", int'(state), 0);
    chk("rst_ms_tick", int'(ms_tick), 0);
    chk("rst_count_en", int'(count_en), 0);
    chk("rst_clear", int'(clear), 0);
    chk("rst_lap_freeze", int'(lap_freeze), 0);

    // Idle after release: ticks on cycles 9, 19, ... with nothing else active.
    rst_n = 1'b1;
    nt = 0; ce = 0; cl = 0; sn = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (ms_tick) nt++;
      if (count_en) ce++;
      if (clear) cl++;
      if (state != 2'd0) sn++;
      chk("tick_cycle", int'(ms_tick), int'(i % 10 == 9));
      @(negedge clk);
    end
    chk("tick_total", nt, 10);
    chk("idle_count_en", ce, 0);
    chk("idle_clear", cl, 0);
    chk("idle_state", sn, 0);

    // Clean start press: count edge lands DIV edges after the IDLE->RUN edge.
    t0 = n_trans;
    b_ss = 1'b1;
    s = -1; e1 = -1; e2 = -1;
    for (int i = 0; i < 250; i++) begin
      if (i == 60) b_ss = 1'b0;
      if (s < 0 && state == 2'd1) s = i;
      if (count_en) begin
        if (e1 < 0) e1 = i;
        else if (e2 < 0) e2 = i;
      end
      @(negedge clk);
    end
    chk("run_seen", int'(s >= 0), 1);
    chk("first_count_en", e1 - s, DIV - 1);
    chk("count_en_period", e2 - e1, DIV);
    chk("clean_press_events", n_trans - t0, 1);
    chk("clean_press_state", int'(state), 1);

    // Bouncing start button.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    t0 = n_trans;
    for (int seg = 0; seg < 6; seg++) begin
      b_ss = (seg % 2 == 0);
      repeat (3) @(negedge clk);
    end
    chk("bounce_no_change", n_trans - t0, 0);
    chk("bounce_state_idle", int'(state), 0);
    b_ss = 1'b1;
    repeat (60) @(negedge clk);
    b_ss = 1'b0;
    repeat (60) @(negedge clk);
    chk("bounce_events", n_trans - t0, 1);
    chk("bounce_state_run", int'(state), 1);

    // Lap: display frozen, counting continues.
    press(1'b0, 1'b1);
    chk("lap_state", int'(state), 2);
    chk("lap_freeze_set", int'(lap_freeze), 1);
    nce = 0;
    repeat (30) begin
      if (count_en) nce++;
      @(negedge clk);
    end
    chk("lap_count_en", nce, 3);
    press(1'b0, 1'b1);
    chk("unlap_state", int'(state), 1);
    chk("unlap_freeze", int'(lap_freeze), 0);

    // Stop, then reset: one clear cycle and the prescaler restarts.
    press(1'b1, 1'b0);
    chk("stop_state", int'(state), 3);
    nce = 0;
    repeat (30) begin
      if (count_en) nce++;
      @(negedge clk);
    end
    chk("stop_count_en", nce, 0);
    b_lr = 1'b1;
    c = -1; t = -1; st_c = -1; nclr = 0;
    for (int i = 0; i < 250; i++) begin
      if (i == 60) b_lr = 1'b0;
      if (clear) begin
        nclr++;
        if (c < 0) begin
          c = i;
          st_c = int'(state);
        end
      end
      if (c >= 0 && i > c && t < 0 && ms_tick) t = i;
      @(negedge clk);
    end
    chk("clear_width", nclr, 1);
    chk("clear_state", st_c, 0);
    chk("tick_after_clear", t - c, DIV - 1);
    chk("cleared_state", int'(state), 0);

    // Table of presses from IDLE.
    exp_prev = 0;
    foreach (tbl[v]) begin
      t0 = n_trans;
      k0 = n_clr;
      press(tbl[v].ss, tbl[v].lr);
      chk($sformatf("vec%0d_state", v), int'(state), tbl[v].st);
      chk($sformatf("vec%0d_freeze", v), int'(lap_freeze), int'(tbl[v].fz));
      chk($sformatf("vec%0d_clear", v), n_clr - k0, tbl[v].clr);
      chk($sformatf("vec%0d_trans", v), n_trans - t0, int'(tbl[v].st != exp_prev));
      exp_prev = tbl[v].st;
    end

    // Asynchronous reset from LAP while count_en is high.
    press(1'b0, 1'b1);
    chk("pre_reset_lap", int'(state), 2);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (count_en) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("pre_reset_count_en", int'(found), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_state", int'(state), 0);
    chk("async_freeze", int'(lap_freeze), 0);
    chk("async_ms_tick", int'(ms_tick), 0);
    chk("async_count_en", int'(count_en), 0);
    chk("async_clear", int'(clear), 0);
    k0 = n_clr;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("reset_no_clear", n_clr - k0, 0);
    chk("post_reset_state", int'(state), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
